// File: rtl/imm_ext_pipe_if.sv
// Valid/ready bundle between the decoder (upstream), imm_ext_pipe and the execute stage.
// The "slave" modport is the unit's view; "master" is the surrounding pipeline's view.
interface imm_ext_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_imm, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_imm, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/imm_ext_pipe.sv
// Immediate extension unit with a 2-entry in-order result buffer and synchronous flush.
// Define IMM_EXT_STAT_EN to add the saturating accepted-transaction counter (stat_cnt_o).
module imm_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,   // must be >= IN_W + 2 for the branch form
  parameter int TAG_W = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  imm_ext_pipe_if.slave bus
`ifdef IMM_EXT_STAT_EN
  ,
  output logic [31:0]   stat_cnt_o
`endif
);
  localparam int EXT_W = OUT_W - IN_W;

  typedef enum logic [1:0] {
    OP_ZERO   = 2'b00,
    OP_SIGN   = 2'b01,
    OP_HIGH   = 2'b10,
    OP_BRANCH = 2'b11
  } op_e;

  function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm, input logic [1:0] op);
    logic [OUT_W-1:0] sext;
    sext = {{EXT_W{imm[IN_W-1]}}, imm};
    case (op_e'(op))
      OP_ZERO:   extend = {{EXT_W{1'b0}}, imm};
      OP_SIGN:   extend = sext;
      OP_HIGH:   extend = {imm, {EXT_W{1'b0}}};
      OP_BRANCH: extend = {sext[OUT_W-3:0], 2'b00};
      default:   extend = {OUT_W{1'b0}};
    endcase
  endfunction

  logic [OUT_W-1:0] data_q [2];
  logic [OUT_W-1:0] data_d [2];
  logic [TAG_W-1:0] tag_q  [2];
  logic [TAG_W-1:0] tag_d  [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             in_ready_s, out_valid_s, push_s, pop_s;

  // Handshake qualification; readiness depends only on registered occupancy.
  always_comb begin
    in_ready_s  = (count_q != 2'd2);
    out_valid_s = (count_q != 2'd0);
    push_s      = bus.in_valid & in_ready_s & ~flush_i;
    pop_s       = out_valid_s & bus.out_ready & ~flush_i;
  end

  // Buffer next-state: flush zeroes entries so the idle head reads as zero.
  always_comb begin
    data_d   = data_q;
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      data_d[0] = {OUT_W{1'b0}};
      data_d[1] = {OUT_W{1'b0}};
      tag_d[0]  = {TAG_W{1'b0}};
      tag_d[1]  = {TAG_W{1'b0}};
      wr_ptr_d  = 1'b0;
      rd_ptr_d  = 1'b0;
      count_d   = 2'd0;
    end else begin
      if (push_s) begin
        data_d[wr_ptr_q] = extend(bus.in_imm, bus.in_op);
        tag_d[wr_ptr_q]  = bus.in_tag;
        wr_ptr_d         = ~wr_ptr_q;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= {OUT_W{1'b0}};
        tag_q[i]  <= {TAG_W{1'b0}};
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= data_d[i];
        tag_q[i]  <= tag_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = data_q[rd_ptr_q];
  assign bus.out_tag   = tag_q[rd_ptr_q];

`ifdef IMM_EXT_STAT_EN
  logic [31:0] stat_q, stat_d;

  // Accept counter survives flush and sticks at all-ones.
  always_comb begin
    stat_d = stat_q;
    if (push_s && (stat_q != 32'hFFFF_FFFF)) begin
      stat_d = stat_q + 32'd1;
    end else begin
      stat_d = stat_q;
    end
  end

  // Accept counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_q <= 32'd0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_cnt_o = stat_q;
`endif
endmodule
